// File: rtl/serial_comp_ctrl_if.sv
// Bundles the upstream/downstream handshakes and the complementer engine hookup.
// slave = sequencer side, master = environment (producer, consumer and engine).
interface serial_comp_ctrl_if #(
    parameter int unsigned W = 4
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         comp_rst_n;
    logic         comp_load;
    logic [W-1:0] comp_num;
    logic [W-1:0] comp_result;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    modport slave (
        input  in_data, in_valid, comp_result, out_ready,
        output in_ready, comp_rst_n, comp_load, comp_num, out_data, out_valid, busy
    );

    modport master (
        output in_data, in_valid, comp_result, out_ready,
        input  in_ready, comp_rst_n, comp_load, comp_num, out_data, out_valid, busy
    );
endinterface

// File: rtl/serial_comp_ctrl.sv
// Sequencer for the bit-serial 2's complementer: clear, load, W shifts, capture,
// then hold the result until the consumer takes it. One word in flight.
module serial_comp_ctrl #(
    parameter int unsigned W = 4
) (
    input  logic               clk,
    input  logic               rst,
    serial_comp_ctrl_if.slave  bus
);
    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SHIFT, CAPT, HOLD} state_e;

    state_e         state_q, state_d;
    logic           in_ready_q, in_ready_d;
    logic           comp_rst_n_q, comp_rst_n_d;
    logic           comp_load_q, comp_load_d;
    logic [W-1:0]   comp_num_q, comp_num_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            comp_rst_n_q <= 1'b0;
            comp_load_q  <= 1'b0;
            comp_num_q   <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            comp_rst_n_q <= comp_rst_n_d;
            comp_load_q  <= comp_load_d;
            comp_num_q   <= comp_num_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        comp_rst_n_d = comp_rst_n_q;
        comp_load_d  = comp_load_q;
        comp_num_d   = comp_num_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                in_ready_d   = 1'b1;
                comp_rst_n_d = 1'b1;
                if (bus.in_valid && in_ready_q) begin
                    comp_num_d   = bus.in_data;
                    in_ready_d   = 1'b0;
                    comp_rst_n_d = 1'b0;
                    state_d      = CLEAR;
                end
            end
            // Engine carry is re-armed to 1 here for every word, not just after rst.
            CLEAR: begin
                comp_rst_n_d = 1'b1;
                comp_load_d  = 1'b1;
                state_d      = LOAD;
            end
            LOAD: begin
                comp_load_d = 1'b0;
                cnt_d       = '0;
                state_d     = SHIFT;
            end
            SHIFT: begin
                if (cnt_q == LAST) begin
                    state_d = CAPT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CAPT: begin
                out_data_d  = bus.comp_result;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                in_ready_d   = 1'b0;
                comp_rst_n_d = 1'b1;
                comp_load_d  = 1'b0;
                out_valid_d  = 1'b0;
                cnt_d        = '0;
            end
        endcase
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.comp_rst_n = comp_rst_n_q;
    assign bus.comp_load  = comp_load_q;
    assign bus.comp_num   = comp_num_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Bench for serial_comp_ctrl with a behavioural bit-serial complementer engine
// and a scoreboard of expected complements.
module tb_serial_comp_ctrl;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rand_rdy = 1'b0;
    logic rdy_dir = 1'b1;
    logic rdy_rnd = 1'b1;

    serial_comp_ctrl_if #(.W(W)) bus ();

    serial_comp_ctrl #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Engine: LSB-first serial negate, result shifted in at the MSB.
    logic [W-1:0] eng_q;
    logic         carry_q;
    always @(posedge clk or negedge bus.comp_rst_n) begin
        if (!bus.comp_rst_n) begin
            eng_q   <= '0;
            carry_q <= 1'b1;
        end else if (bus.comp_load) begin
            eng_q <= bus.comp_num;
        end else begin
            eng_q   <= {(~eng_q[0]) ^ carry_q, eng_q[W-1:1]};
            carry_q <= (~eng_q[0]) & carry_q;
        end
    end
    assign bus.comp_result = eng_q;
    assign bus.out_ready   = rand_rdy ? rdy_rnd : rdy_dir;

    int n_chk = 0;
    int n_bad = 0;
    int n_push = 0;
    int n_pop = 0;
    logic [W-1:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x);
        int unsigned i;
        logic [W-1:0] e;
        i = 0;
        bus.in_data  = x;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && i < 300) begin
            step();
            i++;
        end
        chk("accept_wait", 32'(bus.in_ready), 32'd1);
        if (bus.in_ready) begin
            e = ~x;
            e = e + W'(1);
            sb_q.push_back(e);
            n_push++;
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned i;
        i = 0;
        while (sb_q.size() != 0 && i < 400) begin
            step();
            i++;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
        step();
    endtask

    // Output handshake happens at the coming posedge; pop and compare now.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                n_pop++;
                chk("out_data", 32'(bus.out_data), 32'(e));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        rdy_rnd = ($urandom_range(0, 2) != 0);
    end

    initial begin
        int lat;
        int nlow;
        int nload;
        int unsigned i;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        #1 rst = 1'b1;

        // 1: reset state, then release
        repeat (3) step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_comp_rst_n", 32'(bus.comp_rst_n), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_comp_load", 32'(bus.comp_load), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        step();
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rel_comp_rst_n", 32'(bus.comp_rst_n), 32'd1);

        // 2: single word, latency and pulse widths
        bus.in_data  = 4'b0110;
        bus.in_valid = 1'b1;
        sb_q.push_back(4'b1010);
        n_push++;
        step();
        bus.in_valid = 1'b0;
        chk("t2_in_ready_low", 32'(bus.in_ready), 32'd0);
        lat = 0;
        nlow = 0;
        nload = 0;
        for (int k = 0; k < 20; k++) begin
            if (!bus.comp_rst_n) nlow++;
            if (bus.comp_load) nload++;
            if (bus.out_valid) break;
            step();
            lat++;
        end
        chk("t2_latency", 32'(lat), 32'd7);
        chk("t2_rstn_low_cycles", 32'(nlow), 32'd1);
        chk("t2_load_cycles", 32'(nload), 32'd1);
        chk("t2_out_data", 32'(bus.out_data), 32'(4'b1010));
        chk("t2_in_ready_hold", 32'(bus.in_ready), 32'd0);
        step();
        chk("t2_out_valid_drop", 32'(bus.out_valid), 32'd0);
        chk("t2_in_ready_back", 32'(bus.in_ready), 32'd1);

        // 3: back-to-back, carry must be re-cleared per word
        send(4'b0000);
        send(4'b0001);
        send(4'b1000);
        drain();

        // 4: consumer stall; held in_valid must not be taken
        rdy_dir = 1'b0;
        send(4'b0101);
        i = 0;
        while (!bus.out_valid && i < 30) begin
            step();
            i++;
        end
        chk("t4_valid", 32'(bus.out_valid), 32'd1);
        bus.in_data  = 4'b1111;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("t4_hold_data", 32'(bus.out_data), 32'(4'b1011));
            chk("t4_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        rdy_dir = 1'b1;
        step();
        chk("t4_idle_busy", 32'(bus.busy), 32'd0);
        chk("t4_idle_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t4_sb_empty", 32'(sb_q.size()), 32'd0);

        // 5: reset in SHIFT cycle 2 drops the word
        bus.in_data  = 4'b0111;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        chk("t5_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_comp_rst_n", 32'(bus.comp_rst_n), 32'd0);
        chk("t5_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t5_busy_clr", 32'(bus.busy), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("t5_rel_in_ready", 32'(bus.in_ready), 32'd1);
        send(4'b0011);
        drain();

        // 6: full sweep with random consumer stalls
        rand_rdy = 1'b1;
        for (int x = 0; x < 16; x++) begin
            send(W'(x));
        end
        drain();
        rand_rdy = 1'b0;
        chk("t6_count", 32'(n_pop), 32'(n_push));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
